// File: rtl/motion_bbox_pkg.sv
// Shared definitions for the motion bounding-box block: grid limits,
// coordinate widths, FSM encodings and accumulator init values.
package motion_bbox_pkg;

  localparam int DS_W_DEF = 320;
  localparam int DS_H_DEF = 180;
  localparam int DSX_W    = 10;
  localparam int DSY_W    = 9;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  // Min registers start at all-ones so the first hit always wins the compare
  localparam logic [DSX_W-1:0] X_MIN_INIT = '1;
  localparam logic [DSX_W-1:0] X_MAX_INIT = '0;
  localparam logic [DSY_W-1:0] Y_MIN_INIT = '1;
  localparam logic [DSY_W-1:0] Y_MAX_INIT = '0;

endpackage

// File: rtl/motion_result_reg.sv
// Valid/ready holding register for one result record, with overrun flag
// when a new record lands on one that has not been accepted.
module motion_result_reg #(
  parameter int REC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [REC_W-1:0] next_rec,
  input  logic             ready,
  output logic             valid,
  output logic [REC_W-1:0] rec,
  output logic             overrun
);

  // A load coinciding with acceptance is not an overrun: the old record leaves
  assign overrun = load && valid && !ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      rec   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      rec   <= next_rec;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/motion_bbox.sv
// Accumulates one frame of motion flags into a saturating pixel count and a
// min/max bounding box, publishing a record at end of frame.
module motion_bbox
  import motion_bbox_pkg::*;
#(
  parameter int DS_W       = DS_W_DEF,
  parameter int DS_H       = DS_H_DEF,
  parameter int MIN_PIXELS = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  input  logic             i_sof,
  input  logic             i_eof,
  input  logic [DSX_W-1:0] i_dx,
  input  logic [DSY_W-1:0] i_dy,
  input  logic             i_motion,
  input  logic             i_ready,
  output logic             o_valid,
  output logic             o_detect,
  output logic [CNT_W-1:0] o_count,
  output logic [DSX_W-1:0] o_x_min,
  output logic [DSX_W-1:0] o_x_max,
  output logic [DSY_W-1:0] o_y_min,
  output logic [DSY_W-1:0] o_y_max,
  output logic [1:0]       o_err
);

  localparam int REC_W = 1 + CNT_W + 2 * DSX_W + 2 * DSY_W;
  localparam logic [DSX_W-1:0] X_LIM   = DSX_W'(DS_W);
  localparam logic [DSY_W-1:0] Y_LIM   = DSY_W'(DS_H);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PIXELS);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [DSX_W-1:0] x_min, x_max, x_min_nx, x_max_nx;
  logic [DSY_W-1:0] y_min, y_max, y_min_nx, y_max_nx;
  logic             sof, eof, active, hit, detect, rec_load, overrun;
  logic [REC_W-1:0] next_rec, rec;

  // Stage 0: next accumulator values, including the current pixel
  always_comb begin
    sof    = i_vld && i_sof;
    eof    = i_vld && i_eof;
    active = sof || (state == ST_ACCUM);
    hit    = i_vld && i_motion && (i_dx < X_LIM) && (i_dy < Y_LIM);

    cnt_nx   = sof ? '0 : cnt;
    x_min_nx = sof ? X_MIN_INIT : x_min;
    x_max_nx = sof ? X_MAX_INIT : x_max;
    y_min_nx = sof ? Y_MIN_INIT : y_min;
    y_max_nx = sof ? Y_MAX_INIT : y_max;

    if (hit) begin
      cnt_nx = sat_inc(cnt_nx);
      if (i_dx < x_min_nx) x_min_nx = i_dx;
      if (i_dx > x_max_nx) x_max_nx = i_dx;
      if (i_dy < y_min_nx) y_min_nx = i_dy;
      if (i_dy > y_max_nx) y_max_nx = i_dy;
    end

    rec_load = eof && active;
    detect   = (cnt_nx >= CNT_MIN);
    // Bounding box is meaningless below threshold, so it is reported as zero
    next_rec = {detect, cnt_nx,
                detect ? x_min_nx : '0, detect ? x_max_nx : '0,
                detect ? y_min_nx : '0, detect ? y_max_nx : '0};
  end

  // Stage 1: accumulator, FSM and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      x_min <= X_MIN_INIT;
      x_max <= X_MAX_INIT;
      y_min <= Y_MIN_INIT;
      y_max <= Y_MAX_INIT;
      o_err <= 2'b00;
    end else begin
      if (active) begin
        cnt   <= cnt_nx;
        x_min <= x_min_nx;
        x_max <= x_max_nx;
        y_min <= y_min_nx;
        y_max <= y_max_nx;
      end
      if (sof) state <= eof ? ST_IDLE : ST_ACCUM;
      else if (eof && state == ST_ACCUM) state <= ST_IDLE;
      if (sof && state == ST_ACCUM) o_err[1] <= 1'b1;
      if (overrun) o_err[0] <= 1'b1;
    end
  end

  motion_result_reg #(.REC_W(REC_W)) u_result (
    .clk      (clk),
    .rst      (rst),
    .load     (rec_load),
    .next_rec (next_rec),
    .ready    (i_ready),
    .valid    (o_valid),
    .rec      (rec),
    .overrun  (overrun)
  );

  assign {o_detect, o_count, o_x_min, o_x_max, o_y_min, o_y_max} = rec;

endmodule

// File: tb/tb_motion_bbox.sv
// Directed bench for motion_bbox: frame accumulation, threshold gating,
// range filtering, handshake overrun and error flags.
module tb_motion_bbox;

  logic       clk = 1'b0;
  logic       rst, vld, sof, eof, motion, ready;
  logic [9:0] dx;
  logic [8:0] dy;
  logic       o_valid, o_detect;
  logic [15:0] o_count;
  logic [9:0] o_x_min, o_x_max;
  logic [8:0] o_y_min, o_y_max;
  logic [1:0] o_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  motion_bbox dut (
    .clk(clk), .rst(rst), .i_vld(vld), .i_sof(sof), .i_eof(eof),
    .i_dx(dx), .i_dy(dy), .i_motion(motion), .i_ready(ready),
    .o_valid(o_valid), .o_detect(o_detect), .o_count(o_count),
    .o_x_min(o_x_min), .o_x_max(o_x_max), .o_y_min(o_y_min),
    .o_y_max(o_y_max), .o_err(o_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_rec(input string tag, input int v, input int det, input int cnt,
                           input int xmn, input int xmx, input int ymn, input int ymx,
                           input int err);
    check({tag, ".valid"}, 32'(o_valid), 32'(v));
    check({tag, ".detect"}, 32'(o_detect), 32'(det));
    check({tag, ".count"}, 32'(o_count), 32'(cnt));
    check({tag, ".x_min"}, 32'(o_x_min), 32'(xmn));
    check({tag, ".x_max"}, 32'(o_x_max), 32'(xmx));
    check({tag, ".y_min"}, 32'(o_y_min), 32'(ymn));
    check({tag, ".y_max"}, 32'(o_y_max), 32'(ymx));
    check({tag, ".err"}, 32'(o_err), 32'(err));
  endtask

  task automatic px(input logic s, input logic e, input logic m, input int x, input int y);
    @(negedge clk);
    vld = 1'b1; sof = s; eof = e; motion = m;
    dx = x[9:0]; dy = y[8:0];
  endtask

  task automatic idle();
    @(negedge clk);
    vld = 1'b0; sof = 1'b0; eof = 1'b0; motion = 1'b0;
  endtask

  task automatic accept(input string tag);
    ready = 1'b1;
    @(negedge clk);
    check({tag, ".drop"}, 32'(o_valid), 32'd0);
    ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vld = 1'b0; sof = 1'b0; eof = 1'b0; motion = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);
    check_rec("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; sof = 1'b0; eof = 1'b0; motion = 1'b0;
    ready = 1'b0; dx = '0; dy = '0;
    do_reset();

    // 16-pixel frame with box x 10..50, y 5..100
    px(1, 0, 1, 10, 20);
    px(0, 0, 1, 50, 5);
    px(0, 0, 1, 30, 100);
    for (int k = 0; k < 13; k++) px(0, (k == 12), 1, 20 + k, 50 + k);
    check("t1.latency", 32'(o_valid), 32'd0);
    idle();
    check_rec("t1", 1, 1, 16, 10, 50, 5, 100, 0);
    accept("t1");

    // 15 pixels: below threshold, bbox zeroed
    for (int k = 0; k < 15; k++) px((k == 0), (k == 14), 1, 100 + k, 60);
    idle();
    check_rec("t2", 1, 0, 15, 0, 0, 0, 0, 0);
    accept("t2");

    // Out-of-range coordinates and a non-motion pixel contribute nothing
    px(1, 0, 1, 320, 10);
    px(0, 0, 0, 12, 12);
    px(0, 1, 1, 5, 180);
    idle();
    check_rec("t3", 1, 0, 0, 0, 0, 0, 0, 0);
    accept("t3");

    // SOF and EOF on the same pixel
    px(1, 1, 1, 7, 3);
    idle();
    check_rec("t7", 1, 0, 1, 0, 0, 0, 0, 0);
    accept("t7");

    // EOF while idle is ignored
    px(0, 1, 1, 5, 5);
    idle();
    check("idle_eof.valid", 32'(o_valid), 32'd0);

    // Two records with no acceptance: overwrite and overrun
    px(1, 0, 1, 1, 1);
    px(0, 1, 1, 2, 2);
    idle();
    check("t4a.count", 32'(o_count), 32'd2);
    px(1, 0, 1, 3, 3);
    px(0, 0, 1, 4, 4);
    px(0, 1, 1, 5, 5);
    idle();
    check_rec("t4b", 1, 0, 3, 0, 0, 0, 0, 1);
    accept("t4b");
    check("t4.sticky", 32'(o_err), 32'd1);
    do_reset();

    // New record loaded in the same cycle the old one is accepted
    px(1, 0, 1, 9, 9);
    px(0, 1, 1, 10, 10);
    idle();
    check("t5a.count", 32'(o_count), 32'd2);
    px(1, 0, 1, 11, 11);
    px(0, 0, 1, 12, 12);
    px(0, 1, 1, 13, 13);
    ready = 1'b1;
    check("t5.held", 32'(o_valid), 32'd1);
    idle();
    check_rec("t5b", 1, 0, 3, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t5.drop", 32'(o_valid), 32'd0);
    ready = 1'b0;

    // SOF inside a frame discards the partial frame and flags truncation
    for (int k = 0; k < 5; k++) px((k == 0), 0, 1, 1 + k, 1 + k);
    px(1, 0, 1, 200, 150);
    px(0, 1, 1, 201, 151);
    check("t6.no_rec", 32'(o_valid), 32'd0);
    idle();
    check_rec("t6", 1, 0, 2, 0, 0, 0, 0, 2);
    accept("t6");

    // Reset mid-frame, then a clean 16-pixel frame
    px(1, 0, 1, 40, 40);
    px(0, 0, 1, 41, 41);
    @(negedge clk);
    vld = 1'b0; sof = 1'b0; eof = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_rec("t8.rst", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) px((k == 0), (k == 15), 1, 60 + k, 70);
    idle();
    check_rec("t8", 1, 1, 16, 60, 75, 70, 70, 0);
    accept("t8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
